// File: rtl/mem_ctrl_16_if.sv
// Bus bundle between the core port, the memory controller and the 16-bit memory.
// The slave modport is the controller's view; the master modport is the environment's view.
interface mem_ctrl_16_if #(
    parameter int ADDR_WIDTH = 12
);
    // Core request side
    logic                  CORE_MEMCTRL_req;
    logic                  CORE_MEMCTRL_we;
    logic [1:0]            CORE_MEMCTRL_size;
    logic                  CORE_MEMCTRL_signed;
    logic [ADDR_WIDTH:0]   CORE_MEMCTRL_addr;
    logic [31:0]           CORE_MEMCTRL_wdata;
    // Core response side
    logic                  MEMCTRL_CORE_ready;
    logic                  MEMCTRL_CORE_done;
    logic                  MEMCTRL_CORE_err;
    logic [31:0]           MEMCTRL_CORE_rdata;
    // Memory side
    logic [15:0]           MEM_MEMCTRL_from_mem_data;
    logic                  MEMCTRL_MEM_to_mem_mem_enable;
    logic                  MEMCTRL_MEM_to_mem_read_enable;
    logic                  MEMCTRL_MEM_to_mem_write_enable;
    logic [ADDR_WIDTH-1:0] MEMCTRL_MEM_to_mem_address;
    logic [15:0]           MEMCTRL_MEM_to_mem_data;

    modport slave (
        input  CORE_MEMCTRL_req, CORE_MEMCTRL_we, CORE_MEMCTRL_size,
        input  CORE_MEMCTRL_signed, CORE_MEMCTRL_addr, CORE_MEMCTRL_wdata,
        input  MEM_MEMCTRL_from_mem_data,
        output MEMCTRL_CORE_ready, MEMCTRL_CORE_done, MEMCTRL_CORE_err, MEMCTRL_CORE_rdata,
        output MEMCTRL_MEM_to_mem_mem_enable, MEMCTRL_MEM_to_mem_read_enable,
        output MEMCTRL_MEM_to_mem_write_enable, MEMCTRL_MEM_to_mem_address,
        output MEMCTRL_MEM_to_mem_data
    );

    modport master (
        output CORE_MEMCTRL_req, CORE_MEMCTRL_we, CORE_MEMCTRL_size,
        output CORE_MEMCTRL_signed, CORE_MEMCTRL_addr, CORE_MEMCTRL_wdata,
        output MEM_MEMCTRL_from_mem_data,
        input  MEMCTRL_CORE_ready, MEMCTRL_CORE_done, MEMCTRL_CORE_err, MEMCTRL_CORE_rdata,
        input  MEMCTRL_MEM_to_mem_mem_enable, MEMCTRL_MEM_to_mem_read_enable,
        input  MEMCTRL_MEM_to_mem_write_enable, MEMCTRL_MEM_to_mem_address,
        input  MEMCTRL_MEM_to_mem_data
    );
endinterface

// File: rtl/mem_ctrl_16.sv
// Memory controller: byte/halfword/word core accesses onto a 16-bit synchronous
// memory with one-cycle read latency. Words take two memory cycles, byte writes
// are read-modify-write. All outputs, including the memory strobes, are registered.
module mem_ctrl_16 #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic          clock,
    input  logic          reset,
    mem_ctrl_16_if.slave  bus
);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE0, S_ISSUE1, S_WAIT0, S_WAIT1, S_WRITE, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic                  lsb_q, lsb_d;
    logic [7:0]            byte_q, byte_d;
    logic [15:0]           hi_q, hi_d;
    logic [15:0]           lo_q, lo_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  en_q, en_d;
    logic                  re_q, re_d;
    logic                  wre_q, wre_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [15:0]           mdata_q, mdata_d;

    logic                  illegal;
    logic [7:0]            rd_byte;
    logic [31:0]           rd_ext;
    logic [15:0]           merged;

    // Decode the raw request for alignment errors, and shape returned memory data
    always_comb begin
        illegal = (bus.CORE_MEMCTRL_size == 2'b11)
               || ((bus.CORE_MEMCTRL_size == SZ_HALF) && bus.CORE_MEMCTRL_addr[0])
               || ((bus.CORE_MEMCTRL_size == SZ_WORD) && (bus.CORE_MEMCTRL_addr[1:0] != 2'b00));
        rd_byte = lsb_q ? bus.MEM_MEMCTRL_from_mem_data[15:8] : bus.MEM_MEMCTRL_from_mem_data[7:0];
        if (size_q == SZ_BYTE)
            rd_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
        else
            rd_ext = {{16{signed_q & bus.MEM_MEMCTRL_from_mem_data[15]}}, bus.MEM_MEMCTRL_from_mem_data};
        merged = lsb_q ? {byte_q, bus.MEM_MEMCTRL_from_mem_data[7:0]}
                       : {bus.MEM_MEMCTRL_from_mem_data[15:8], byte_q};
    end

    // Next-state and next-output logic; memory strobes are set for the state being entered
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        lsb_d    = lsb_q;
        byte_d   = byte_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        en_d     = 1'b0;
        re_d     = 1'b0;
        wre_d    = 1'b0;
        maddr_d  = maddr_q;
        mdata_d  = mdata_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (bus.CORE_MEMCTRL_req) begin
                    ready_d  = 1'b0;
                    we_d     = bus.CORE_MEMCTRL_we;
                    size_d   = bus.CORE_MEMCTRL_size;
                    signed_d = bus.CORE_MEMCTRL_signed;
                    lsb_d    = bus.CORE_MEMCTRL_addr[0];
                    byte_d   = bus.CORE_MEMCTRL_wdata[7:0];
                    hi_d     = bus.CORE_MEMCTRL_wdata[31:16];
                    if (illegal) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_ISSUE0;
                        en_d    = 1'b1;
                        maddr_d = bus.CORE_MEMCTRL_addr[ADDR_WIDTH:1];
                        // Byte writes start with a read of the containing halfword
                        if (bus.CORE_MEMCTRL_we && (bus.CORE_MEMCTRL_size != SZ_BYTE)) begin
                            wre_d   = 1'b1;
                            mdata_d = bus.CORE_MEMCTRL_wdata[15:0];
                        end else begin
                            re_d = 1'b1;
                        end
                    end
                end
            end
            S_ISSUE0: begin
                if (size_q == SZ_WORD) begin
                    // Second half goes out while the first read's data returns
                    state_d = S_ISSUE1;
                    en_d    = 1'b1;
                    maddr_d = maddr_q + ADDR_ONE;
                    if (we_q) begin
                        wre_d   = 1'b1;
                        mdata_d = hi_q;
                    end else begin
                        re_d = 1'b1;
                    end
                end else if (we_q && (size_q == SZ_HALF)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_WAIT0;
                end
            end
            S_ISSUE1: begin
                if (we_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    lo_d    = bus.MEM_MEMCTRL_from_mem_data;
                    state_d = S_WAIT1;
                end
            end
            S_WAIT0: begin
                if (we_q) begin
                    state_d = S_WRITE;
                    en_d    = 1'b1;
                    wre_d   = 1'b1;
                    mdata_d = merged;
                end else begin
                    rdata_d = rd_ext;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_WAIT1: begin
                rdata_d = {bus.MEM_MEMCTRL_from_mem_data, lo_q};
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_WRITE: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset abandons any access in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            lsb_q    <= 1'b0;
            byte_q   <= 8'h00;
            hi_q     <= 16'h0000;
            lo_q     <= 16'h0000;
            rdata_q  <= 32'h0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            en_q     <= 1'b0;
            re_q     <= 1'b0;
            wre_q    <= 1'b0;
            maddr_q  <= '0;
            mdata_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            lsb_q    <= lsb_d;
            byte_q   <= byte_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
            en_q     <= en_d;
            re_q     <= re_d;
            wre_q    <= wre_d;
            maddr_q  <= maddr_d;
            mdata_q  <= mdata_d;
        end
    end

    assign bus.MEMCTRL_CORE_ready              = ready_q;
    assign bus.MEMCTRL_CORE_done               = done_q;
    assign bus.MEMCTRL_CORE_err                = err_q;
    assign bus.MEMCTRL_CORE_rdata              = rdata_q;
    assign bus.MEMCTRL_MEM_to_mem_mem_enable   = en_q;
    assign bus.MEMCTRL_MEM_to_mem_read_enable  = re_q;
    assign bus.MEMCTRL_MEM_to_mem_write_enable = wre_q;
    assign bus.MEMCTRL_MEM_to_mem_address      = maddr_q;
    assign bus.MEMCTRL_MEM_to_mem_data         = mdata_q;
endmodule

// File: tb/tb_mem_ctrl_16.sv
// Directed bench for mem_ctrl_16 with a behavioural 4096x16 latency-1 memory.
module tb_mem_ctrl_16;
    logic clock = 1'b0;
    logic reset = 1'b0;

    mem_ctrl_16_if #(.ADDR_WIDTH(12)) ifc ();
    mem_ctrl_16 #(.ADDR_WIDTH(12)) dut (.clock(clock), .reset(reset), .bus(ifc));

    initial forever #5 clock = ~clock;

    int tests_run = 0;
    int tests_failed = 0;

    // Memory model plus bus activity counters
    logic [15:0] mem [0:4095];
    logic [15:0] mem_q = 16'h0000;
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = 12'h0;
    logic [15:0] pl_data = 16'h0;
    int cyc = 0, cnt_en = 0, cnt_rd = 0, cnt_wr = 0, cnt_pair = 0, cnt_done = 0;
    int last_rd_cyc = -100, last_wr_cyc = -100;
    logic prev_rd = 1'b0;
    logic cur_rd, cur_wr;

    assign ifc.MEM_MEMCTRL_from_mem_data = mem_q;

    always @(posedge clock) begin
        cyc++;
        cur_rd = ifc.MEMCTRL_MEM_to_mem_mem_enable && ifc.MEMCTRL_MEM_to_mem_read_enable;
        cur_wr = ifc.MEMCTRL_MEM_to_mem_mem_enable && ifc.MEMCTRL_MEM_to_mem_write_enable;
        if (pl_en) mem[pl_addr] <= pl_data;
        if (cur_wr) mem[ifc.MEMCTRL_MEM_to_mem_address] <= ifc.MEMCTRL_MEM_to_mem_data;
        if (cur_rd) mem_q <= mem[ifc.MEMCTRL_MEM_to_mem_address];
        if (ifc.MEMCTRL_MEM_to_mem_mem_enable) cnt_en++;
        if (cur_rd) begin
            cnt_rd++;
            if (prev_rd) cnt_pair++;
            last_rd_cyc = cyc;
        end
        prev_rd = cur_rd;
        if (cur_wr) begin
            cnt_wr++;
            last_wr_cyc = cyc;
        end
        if (ifc.MEMCTRL_CORE_done) cnt_done++;
    end

    int b_en, b_rd, b_wr, b_pair;
    int lat;
    logic err_seen;

    task automatic preload(input logic [11:0] a, input logic [15:0] d);
        @(negedge clock);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    // Issue one request, then scramble the core inputs and count cycles to done
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [12:0] addr, input logic [31:0] wdata);
        @(negedge clock);
        ifc.CORE_MEMCTRL_req = 1'b1; ifc.CORE_MEMCTRL_we = we; ifc.CORE_MEMCTRL_size = size;
        ifc.CORE_MEMCTRL_signed = sgn; ifc.CORE_MEMCTRL_addr = addr; ifc.CORE_MEMCTRL_wdata = wdata;
        @(posedge clock);
        #1;
        ifc.CORE_MEMCTRL_req = 1'b0; ifc.CORE_MEMCTRL_we = ~we; ifc.CORE_MEMCTRL_size = ~size;
        ifc.CORE_MEMCTRL_signed = ~sgn; ifc.CORE_MEMCTRL_addr = ~addr; ifc.CORE_MEMCTRL_wdata = 32'hDEADDEAD;
        b_en = cnt_en; b_rd = cnt_rd; b_wr = cnt_wr; b_pair = cnt_pair;
        lat = -1; err_seen = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (ifc.MEMCTRL_CORE_done) begin
                lat = c;
                err_seen = ifc.MEMCTRL_CORE_err;
                break;
            end
        end
        $display("[TB] req we=%0b size=%0b signed=%0b addr=%h wdata=%h -> lat=%0d err=%0b rdata=%h",
                 we, size, sgn, addr, wdata, lat, err_seen, ifc.MEMCTRL_CORE_rdata);
    endtask

    task automatic test_reset();
        ifc.CORE_MEMCTRL_req = 1'b0; ifc.CORE_MEMCTRL_we = 1'b0; ifc.CORE_MEMCTRL_size = 2'b00;
        ifc.CORE_MEMCTRL_signed = 1'b0; ifc.CORE_MEMCTRL_addr = 13'h0; ifc.CORE_MEMCTRL_wdata = 32'h0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        tests_run++; if (ifc.MEMCTRL_CORE_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", ifc.MEMCTRL_CORE_ready); end
        tests_run++; if (ifc.MEMCTRL_CORE_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", ifc.MEMCTRL_CORE_done); end
        tests_run++; if (ifc.MEMCTRL_CORE_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", ifc.MEMCTRL_CORE_err); end
        tests_run++; if (ifc.MEMCTRL_CORE_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h want 0", ifc.MEMCTRL_CORE_rdata); end
        tests_run++; if ({ifc.MEMCTRL_MEM_to_mem_mem_enable, ifc.MEMCTRL_MEM_to_mem_read_enable, ifc.MEMCTRL_MEM_to_mem_write_enable} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_enables: got %b%b%b want 000", ifc.MEMCTRL_MEM_to_mem_mem_enable, ifc.MEMCTRL_MEM_to_mem_read_enable, ifc.MEMCTRL_MEM_to_mem_write_enable); end
        tests_run++; if (ifc.MEMCTRL_MEM_to_mem_address !== 12'h0) begin tests_failed++; $display("FAIL reset_address: got %h want 0", ifc.MEMCTRL_MEM_to_mem_address); end
        tests_run++; if (ifc.MEMCTRL_MEM_to_mem_data !== 16'h0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", ifc.MEMCTRL_MEM_to_mem_data); end
        reset = 1'b1;
    endtask

    task automatic test_halfword_read();
        preload(12'h010, 16'hBEEF);
        do_req(1'b0, 2'b01, 1'b0, 13'h0020, 32'h0);
        tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL hw_read_latency: got %0d want 3", lat); end
        tests_run++; if (ifc.MEMCTRL_CORE_rdata !== 32'h0000BEEF) begin tests_failed++; $display("FAIL hw_read_unsigned: got %h want 0000beef", ifc.MEMCTRL_CORE_rdata); end
        tests_run++; if (err_seen !== 1'b0) begin tests_failed++; $display("FAIL hw_read_err: got %b want 0", err_seen); end
        tests_run++; if ((cnt_rd - b_rd) != 1 || (cnt_wr - b_wr) != 0) begin tests_failed++; $display("FAIL hw_read_cycles: got rd=%0d wr=%0d want rd=1 wr=0", cnt_rd - b_rd, cnt_wr - b_wr); end
        do_req(1'b0, 2'b01, 1'b1, 13'h0020, 32'h0);
        tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL hw_read_signed_latency: got %0d want 3", lat); end
        tests_run++; if (ifc.MEMCTRL_CORE_rdata !== 32'hFFFFBEEF) begin tests_failed++; $display("FAIL hw_read_signed: got %h want ffffbeef", ifc.MEMCTRL_CORE_rdata); end
    endtask

    task automatic test_word();
        do_req(1'b1, 2'b10, 1'b0, 13'h1FFC, 32'h12345678);
        tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL word_write_latency: got %0d want 3", lat); end
        tests_run++; if (mem[12'hFFE] !== 16'h5678) begin tests_failed++; $display("FAIL word_write_low: got %h want 5678", mem[12'hFFE]); end
        tests_run++; if (mem[12'hFFF] !== 16'h1234) begin tests_failed++; $display("FAIL word_write_high: got %h want 1234", mem[12'hFFF]); end
        tests_run++; if ((cnt_wr - b_wr) != 2 || (cnt_rd - b_rd) != 0) begin tests_failed++; $display("FAIL word_write_cycles: got wr=%0d rd=%0d want wr=2 rd=0", cnt_wr - b_wr, cnt_rd - b_rd); end
        tests_run++; if (ifc.MEMCTRL_CORE_rdata !== 32'hFFFFBEEF) begin tests_failed++; $display("FAIL write_keeps_rdata: got %h want ffffbeef", ifc.MEMCTRL_CORE_rdata); end
        do_req(1'b0, 2'b10, 1'b1, 13'h1FFC, 32'h0);
        tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL word_read_latency: got %0d want 4", lat); end
        tests_run++; if (ifc.MEMCTRL_CORE_rdata !== 32'h12345678) begin tests_failed++; $display("FAIL word_read_data: got %h want 12345678", ifc.MEMCTRL_CORE_rdata); end
        tests_run++; if ((cnt_rd - b_rd) != 2 || (cnt_pair - b_pair) != 1) begin tests_failed++; $display("FAIL word_read_pipelined: got rd=%0d adjacent=%0d want rd=2 adjacent=1", cnt_rd - b_rd, cnt_pair - b_pair); end
    endtask

    task automatic test_byte();
        preload(12'h004, 16'hAABB);
        preload(12'h002, 16'h80FF);
        do_req(1'b1, 2'b00, 1'b0, 13'h0009, 32'hFFFFFF5C);
        tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL byte_write_latency: got %0d want 4", lat); end
        tests_run++; if ((cnt_rd - b_rd) != 1 || (cnt_wr - b_wr) != 1) begin tests_failed++; $display("FAIL byte_write_cycles: got rd=%0d wr=%0d want rd=1 wr=1", cnt_rd - b_rd, cnt_wr - b_wr); end
        tests_run++; if ((last_wr_cyc - last_rd_cyc) != 2) begin tests_failed++; $display("FAIL byte_write_order: got write-read gap %0d want 2", last_wr_cyc - last_rd_cyc); end
        tests_run++; if (mem[12'h004] !== 16'h5CBB) begin tests_failed++; $display("FAIL byte_write_merge: got %h want 5cbb", mem[12'h004]); end
        do_req(1'b0, 2'b00, 1'b0, 13'h0008, 32'h0);
        tests_run++; if (ifc.MEMCTRL_CORE_rdata !== 32'h000000BB || lat !== 3) begin tests_failed++; $display("FAIL byte_read_low: got %h lat %0d want 000000bb lat 3", ifc.MEMCTRL_CORE_rdata, lat); end
        do_req(1'b0, 2'b00, 1'b1, 13'h0005, 32'h0);
        tests_run++; if (ifc.MEMCTRL_CORE_rdata !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL byte_read_signed_neg: got %h want ffffff80", ifc.MEMCTRL_CORE_rdata); end
        do_req(1'b0, 2'b00, 1'b1, 13'h0009, 32'h0);
        tests_run++; if (ifc.MEMCTRL_CORE_rdata !== 32'h0000005C) begin tests_failed++; $display("FAIL byte_read_signed_pos: got %h want 0000005c", ifc.MEMCTRL_CORE_rdata); end
    endtask

    task automatic test_errors();
        logic [1:0]  sizes [3];
        logic [12:0] addrs [3];
        sizes[0] = 2'b10; addrs[0] = 13'h0002;
        sizes[1] = 2'b01; addrs[1] = 13'h0003;
        sizes[2] = 2'b11; addrs[2] = 13'h0000;
        do_req(1'b0, 2'b01, 1'b0, 13'h0020, 32'h0);
        tests_run++; if (ifc.MEMCTRL_CORE_rdata !== 32'h0000BEEF) begin tests_failed++; $display("FAIL err_setup_read: got %h want 0000beef", ifc.MEMCTRL_CORE_rdata); end
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, sizes[i], 1'b1, addrs[i], 32'h0);
            tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL err%0d_latency: got %0d want 1", i, lat); end
            tests_run++; if (err_seen !== 1'b1) begin tests_failed++; $display("FAIL err%0d_flag: got %b want 1", i, err_seen); end
            tests_run++; if ((cnt_en - b_en) != 0) begin tests_failed++; $display("FAIL err%0d_no_mem_cycle: got %0d enables want 0", i, cnt_en - b_en); end
            tests_run++; if (ifc.MEMCTRL_CORE_rdata !== 32'h0000BEEF) begin tests_failed++; $display("FAIL err%0d_rdata_kept: got %h want 0000beef", i, ifc.MEMCTRL_CORE_rdata); end
        end
    endtask

    task automatic test_back_to_back();
        int bad_ready = 0;
        int first_done = -1;
        int second_done = -1;
        logic [31:0] r1 = 32'h0;
        logic [31:0] r2 = 32'h0;
        @(negedge clock);
        ifc.CORE_MEMCTRL_req = 1'b1; ifc.CORE_MEMCTRL_we = 1'b0; ifc.CORE_MEMCTRL_size = 2'b01;
        ifc.CORE_MEMCTRL_signed = 1'b0; ifc.CORE_MEMCTRL_addr = 13'h0020; ifc.CORE_MEMCTRL_wdata = 32'h0;
        @(posedge clock);
        #1;
        ifc.CORE_MEMCTRL_size = 2'b10; ifc.CORE_MEMCTRL_addr = 13'h1FFC;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            if (ifc.MEMCTRL_CORE_ready !== (n == 4)) bad_ready++;
            if (n == 5) ifc.CORE_MEMCTRL_req = 1'b0;
            if (ifc.MEMCTRL_CORE_done) begin
                if (first_done < 0) begin
                    first_done = n; r1 = ifc.MEMCTRL_CORE_rdata;
                end else begin
                    second_done = n; r2 = ifc.MEMCTRL_CORE_rdata;
                    break;
                end
            end
        end
        ifc.CORE_MEMCTRL_req = 1'b0;
        $display("[TB] back-to-back hw+word: done at %0d and %0d, rdata %h then %h", first_done, second_done, r1, r2);
        tests_run++; if (first_done !== 3 || r1 !== 32'h0000BEEF) begin tests_failed++; $display("FAIL b2b_first: got done@%0d %h want done@3 0000beef", first_done, r1); end
        tests_run++; if (second_done !== 8 || r2 !== 32'h12345678) begin tests_failed++; $display("FAIL b2b_second: got done@%0d %h want done@8 12345678", second_done, r2); end
        tests_run++; if (bad_ready != 0) begin tests_failed++; $display("FAIL b2b_ready: got %0d wrong ready cycles want 0", bad_ready); end
    endtask

    task automatic test_reset_mid();
        int b_done;
        preload(12'h080, 16'h0000);
        preload(12'h081, 16'h7777);
        @(negedge clock);
        ifc.CORE_MEMCTRL_req = 1'b1; ifc.CORE_MEMCTRL_we = 1'b1; ifc.CORE_MEMCTRL_size = 2'b10;
        ifc.CORE_MEMCTRL_signed = 1'b0; ifc.CORE_MEMCTRL_addr = 13'h0100; ifc.CORE_MEMCTRL_wdata = 32'hAAAA5555;
        @(posedge clock);
        #1;
        ifc.CORE_MEMCTRL_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        tests_run++; if (ifc.MEMCTRL_MEM_to_mem_write_enable !== 1'b1 || ifc.MEMCTRL_MEM_to_mem_address !== 12'h081) begin
            tests_failed++; $display("FAIL rst_mid_in_issue1: got we=%b addr=%h want we=1 addr=081", ifc.MEMCTRL_MEM_to_mem_write_enable, ifc.MEMCTRL_MEM_to_mem_address); end
        b_done = cnt_done;
        reset = 1'b0;
        #1;
        tests_run++; if ({ifc.MEMCTRL_MEM_to_mem_mem_enable, ifc.MEMCTRL_MEM_to_mem_read_enable, ifc.MEMCTRL_MEM_to_mem_write_enable} !== 3'b000) begin
            tests_failed++; $display("FAIL rst_mid_enables: got %b%b%b want 000", ifc.MEMCTRL_MEM_to_mem_mem_enable, ifc.MEMCTRL_MEM_to_mem_read_enable, ifc.MEMCTRL_MEM_to_mem_write_enable); end
        tests_run++; if (ifc.MEMCTRL_CORE_ready !== 1'b1 || ifc.MEMCTRL_CORE_done !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_ready_done: got ready=%b done=%b want ready=1 done=0", ifc.MEMCTRL_CORE_ready, ifc.MEMCTRL_CORE_done); end
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        $display("[TB] reset during word write issue1: mem[080]=%h mem[081]=%h", mem[12'h080], mem[12'h081]);
        tests_run++; if (cnt_done != b_done) begin tests_failed++; $display("FAIL rst_mid_no_done: got %0d done pulses want 0", cnt_done - b_done); end
        tests_run++; if (mem[12'h081] !== 16'h7777) begin tests_failed++; $display("FAIL rst_mid_high_unwritten: got %h want 7777", mem[12'h081]); end
        tests_run++; if (mem[12'h080] !== 16'h5555) begin tests_failed++; $display("FAIL rst_mid_low_written: got %h want 5555", mem[12'h080]); end
        tests_run++; if (ifc.MEMCTRL_CORE_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_ready_after: got %b want 1", ifc.MEMCTRL_CORE_ready); end
        do_req(1'b0, 2'b01, 1'b0, 13'h0020, 32'h0);
        tests_run++; if (lat !== 3 || ifc.MEMCTRL_CORE_rdata !== 32'h0000BEEF) begin tests_failed++; $display("FAIL rst_mid_recover: got %h lat %0d want 0000beef lat 3", ifc.MEMCTRL_CORE_rdata, lat); end
    endtask

    initial begin
        test_reset();
        test_halfword_read();
        test_word();
        test_byte();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_ctrl_16.md
# mem_ctrl_16

Memory controller between the CPU core's load/store/fetch port and the single-port 16-bit, 4096-word synchronous memory. Accepts byte, halfword and word requests on byte addresses. Splits 32-bit accesses into two 16-bit memory cycles and performs byte writes as read-modify-write. Drives the `MEMCTRL_MEM_to_mem_*` bus and consumes `MEM_MEMCTRL_from_mem_data`.

## Interface
- `ADDR_WIDTH`, 12: memory word-address width; the byte address is `ADDR_WIDTH+1` bits.
- `clock` in 1: single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-low reset (0 = reset).
- `CORE_MEMCTRL_req` in 1: request valid; sampled only while `ready`=1.
- `CORE_MEMCTRL_we` in 1: 1 = write, 0 = read.
- `CORE_MEMCTRL_size` in 2: 00 = byte, 01 = halfword, 10 = word, 11 = illegal (flagged as an error).
- `CORE_MEMCTRL_signed` in 1: sign-extend byte/halfword reads.
- `CORE_MEMCTRL_addr` in 13: byte address.
- `CORE_MEMCTRL_wdata` in 32: write data, right-aligned.
- `MEMCTRL_CORE_ready` out 1: controller idle and able to accept a request.
- `MEMCTRL_CORE_done` out 1: one-cycle completion pulse.
- `MEMCTRL_CORE_err` out 1: pulses together with `done` on a misaligned or illegal request.
- `MEMCTRL_CORE_rdata` out 32: read result; valid while `done`=1 for a read, and held until the next completed read.
- `MEM_MEMCTRL_from_mem_data` in 16: memory read data.
- `MEMCTRL_MEM_to_mem_mem_enable` out 1: memory enable.
- `MEMCTRL_MEM_to_mem_read_enable` out 1: memory read enable.
- `MEMCTRL_MEM_to_mem_write_enable` out 1: memory write enable.
- `MEMCTRL_MEM_to_mem_address` out 12: memory word address.
- `MEMCTRL_MEM_to_mem_data` out 16: memory write data.

## Operation
- **Memory model.**
  - The memory samples `address`, `enable`, `read_enable` and `write_enable` at each rising edge.
  - Read data is valid during the cycle after the sampling edge (latency 1).
  - A write takes effect at the sampling edge.
- **Addressing and endianness.**
  - Little-endian. Word address = `addr[12:1]`.
  - Byte lane: `addr[0]`=0 selects `[7:0]`, 1 selects `[15:8]`.
  - A word occupies word addresses A (low half) and A+1 (high half), with A = `addr[12:1]`.
  - `addr[1:0]` = 00 is required for words, so A+1 never wraps.
- **Request capture.** `req` and `ready` high at edge E0 → `we`, `size`, `signed`, `addr` and `wdata` are latched. The core may change its inputs after E0.
- **Alignment check.** A halfword with `addr[0]`=1, a word with `addr[1:0]`≠00, or `size`=11 is an error. The controller performs no memory cycle and pulses `done` and `err` together.
- **States.**
  - IDLE → ISSUE0 on a legal request; IDLE → DONE on an error.
  - Halfword/byte read: ISSUE0 (read A) → WAIT0 (capture) → DONE.
  - Word read: ISSUE0 (read A) → ISSUE1 (read A+1, capture low) → WAIT1 (capture high) → DONE.
  - Halfword write: ISSUE0 (write A) → DONE.
  - Word write: ISSUE0 (write A, `wdata[15:0]`) → ISSUE1 (write A+1, `wdata[31:16]`) → DONE.
  - Byte write: ISSUE0 (read A) → WAIT0 (merge `wdata[7:0]` into the selected lane of the captured halfword) → WRITE (write A) → DONE.
  - DONE → IDLE unconditionally.
- **Memory outputs.** `mem_enable` is 1 in every issue/write state and 0 otherwise. `read_enable` and `write_enable` are mutually exclusive and both 0 in IDLE, WAIT and DONE states. `address` and `data` are don't-care when `mem_enable`=0, but must not be X.
- **Read result.**
  - Byte read: selected lane, zero-extended or sign-extended per `signed`.
  - Halfword read: zero-extended or sign-extended per `signed`.
  - Word read: `{high, low}`; `signed` is ignored.
- **Writes.** `rdata` is unchanged by writes and by errors.
- **`ready`.** `ready` = (state == IDLE). `req` while `ready`=0 is ignored; the core holds `req` until it is accepted.
- **Reset.** While `reset`=0, asynchronously:
  - state = IDLE;
  - `ready`=1;
  - `done`, `err`, `rdata`, `mem_enable`, `read_enable`, `write_enable`, `address` and `data` = 0.
- **Reset mid-operation.** The access is abandoned and no `done` is produced. A byte write interrupted before WRITE leaves memory unchanged.

## Timing
- Latency is counted in cycles from the acceptance edge E0 to the cycle in which `done`=1.
  - Halfword/byte read: 3.
  - Word read: 4.
  - Halfword write: 2.
  - Word write: 3.
  - Byte write: 4.
  - Error: 1.
- Reads are pipelined: in a word read, the high-half read is issued in the same cycle that the low-half data arrives.
- Minimum spacing between acceptances is latency + 1, since DONE is followed by IDLE.
- `done` and `err` are registered, one cycle wide, and never high while `reset`=0.
- The first acceptance after reset release is possible at the first rising edge with `reset`=1.

## Test plan
- **Halfword read.** Preload word 0x010 = 0xBEEF. Halfword read at `addr`=0x020, `signed`=0 → `done` at E0+3 with `rdata`=0x0000BEEF. Repeat with `signed`=1 → `rdata`=0xFFFFBEEF.
- **Word write then read.** Word write of 0x12345678 to `addr`=0x1FFC → memory 0xFFE = 0x5678 and 0xFFF = 0x1234, `done` at E0+3. Word read of the same address → `rdata`=0x12345678 at E0+4, with two consecutive read-issue cycles.
- **Byte write (RMW).** Preload 0x004 = 0xAABB. Byte write of 0x5C to `addr`=0x009 → exactly one read followed by one write, memory 0x004 = 0x5CBB, `done` at E0+4. Byte read of `addr`=0x008 → 0x000000BB.
- **Misaligned and illegal.** Word request at `addr`=0x002, halfword at 0x003, and `size`=11 → `done`=`err`=1 at E0+1, `mem_enable` never asserted, `rdata` unchanged.
- **Back-to-back.** `req` held high continuously for a halfword read followed by a word read → the second request is accepted only after DONE→IDLE, and `ready` is 0 throughout each access.
- **Reset mid-operation.** Assert `reset`=0 during ISSUE1 of a word write → all enables drop immediately, there is no `done`, A+1 is not written, and `ready`=1 after release.
